i2s_sample_tx: RTL and testbench

- Audio output end of the synth's sample path: takes one mono PCM sample per frame through a valid/ready handshake and serialises it onto a standard I2S link (bclk, lrclk, sdata) towards an external DAC.
- Generates its own bit clock from the system clock and emits a one-cycle frame strobe.
- Upstream voice/mixer logic uses this strobe as its sample-rate pacing signal.
- Double-buffered: one holding register plus one shift register.

---
 rtl/i2s_sample_tx_pkg.sv | 16 +
 rtl/i2s_sample_tx_if.sv | 40 ++++
 rtl/i2s_bclk_gen.sv | 38 +++
 rtl/i2s_sample_tx.sv | 125 ++++++++++++
 tb/tb_i2s_sample_tx.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_sample_tx_pkg.sv
// Shared synth constants: common sample width and the I2S frame length helper.
// Other synth blocks (oscillator, ADSR, mixer) reuse SAMPLE_W.
package i2s_sample_tx_pkg;

  localparam int SAMPLE_W     = 16;
  localparam int DEF_SLOT_W   = 16;
  localparam int DEF_BCLK_DIV = 4;

  // clk cycles per stereo frame: 2 slots * slot_w bits * 2 half-periods * bclk_div
  function automatic int frame_clks(input int slot_w, input int bclk_div);
    return 4 * slot_w * bclk_div;
  endfunction

  localparam int FRAME_CLKS = frame_clks(DEF_SLOT_W, DEF_BCLK_DIV);

endpackage

// File: rtl/i2s_sample_tx_if.sv
// Sample handshake plus I2S pins of the audio output stage.
// slave = transmitter side, master = sample source / link observer.
interface i2s_sample_tx_if
  import i2s_sample_tx_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
);

  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              frame_tick;
  logic              underrun;
  logic              bclk;
  logic              lrclk;
  logic              sdata;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready,
    input  frame_tick,
    input  underrun,
    input  bclk,
    input  lrclk,
    input  sdata
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready,
    output frame_tick,
    output underrun,
    output bclk,
    output lrclk,
    output sdata
  );

endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit clock divider: bclk toggles every BCLK_DIV clk cycles; fall_o flags the cycle
// in which bclk is about to go 1->0 (combinational, no backpressure).
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk_i,
  input  logic arst_i,
  output logic bclk_o,
  output logic fall_o
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             wrap;

  always_comb begin
    wrap      = (div_cnt_q == DIV_LAST);
    div_cnt_d = wrap ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d    = wrap ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk_o = bclk_q;
  assign fall_o = wrap & bclk_q;

endmodule

// File: rtl/i2s_sample_tx.sv
// Mono PCM to I2S serialiser with one holding register; frame_tick paces upstream.
// Outputs change on bclk falling edges; sample_ready drops while a sample is held.
module i2s_sample_tx
  import i2s_sample_tx_pkg::*;
#(
  parameter int DATA_W   = SAMPLE_W,
  parameter int SLOT_W   = DEF_SLOT_W,
  parameter int BCLK_DIV = DEF_BCLK_DIV
) (
  input  logic           clk_i,
  input  logic           arst_i,
  i2s_sample_tx_if.slave tx_if
);

  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int BIT_W      = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] LR_LO    = BIT_W'(SLOT_W - 1);
  localparam logic [BIT_W-1:0] LR_HI    = BIT_W'(FRAME_BITS - 2);

  function automatic logic [SLOT_W-1:0] to_slot(input logic [DATA_W-1:0] s);
    logic [SLOT_W-1:0] r;
    r = '0;
    r[SLOT_W-1 -: DATA_W] = s;
    return r;
  endfunction

  logic                  bclk, fall;
  logic                  load;
  logic [DATA_W-1:0]     src;
  logic [SLOT_W-1:0]     src_slot;

  logic [DATA_W-1:0]     hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_W-1:0]     last_q, last_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  lrclk_q, lrclk_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  underrun_q, underrun_d;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .bclk_o (bclk),
    .fall_o (fall)
  );

  always_comb begin
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    last_d       = last_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    lrclk_d      = lrclk_q;
    frame_tick_d = 1'b0;
    underrun_d   = 1'b0;
    src          = last_q;
    src_slot     = '0;
    load         = fall && (bit_cnt_q == BIT_LAST);

    if (load) begin
      // Held sample first, then a same-cycle bypass, else repeat the previous one.
      if (hold_full_q) begin
        src         = hold_q;
        hold_full_d = 1'b0;
      end else if (tx_if.sample_valid) begin
        src = tx_if.sample_in;
      end else begin
        underrun_d = 1'b1;
      end
      src_slot     = to_slot(src);
      shift_d      = {src_slot, src_slot};
      bit_cnt_d    = '0;
      last_d       = src;
      frame_tick_d = 1'b1;
    end else begin
      if (tx_if.sample_valid && !hold_full_q) begin
        hold_d      = tx_if.sample_in;
        hold_full_d = 1'b1;
      end
      if (fall) begin
        shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
    end

    // Word select leads the slot MSB by one bit time.
    if (fall) begin
      lrclk_d = (bit_cnt_d >= LR_LO) && (bit_cnt_d <= LR_HI);
    end
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      last_q       <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= BIT_LAST;
      lrclk_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      last_q       <= last_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      lrclk_q      <= lrclk_d;
      frame_tick_q <= frame_tick_d;
      underrun_q   <= underrun_d;
    end
  end

  assign tx_if.sample_ready = ~hold_full_q;
  assign tx_if.frame_tick   = frame_tick_q;
  assign tx_if.underrun     = underrun_q;
  assign tx_if.bclk         = bclk;
  assign tx_if.lrclk        = lrclk_q;
  assign tx_if.sdata        = shift_q[FRAME_BITS-1];

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Bench for i2s_sample_tx: cycle-count based reference model plus directed frame decodes.
module tb_i2s_sample_tx;
  import i2s_sample_tx_pkg::*;

  localparam int DW = 16;
  localparam int SW = 16;
  localparam int BD = 2;
  localparam int P  = 2 * BD;
  localparam int FR = frame_clks(SW, BD);
  localparam int NB = 2 * SW;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  i2s_sample_tx_if #(.DATA_W(DW)) tx_if ();

  i2s_sample_tx #(
    .DATA_W   (DW),
    .SLOT_W   (SW),
    .BCLK_DIV (BD)
  ) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .tx_if  (tx_if)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int          n = 0;
  bit          held = 0;
  logic [15:0] hold_v = '0;
  logic [15:0] last_v = '0;
  logic [15:0] cur_v = '0;
  bit          ur_m = 0;
  bit          last_acc = 0;

  // frame decode from the DUT pins
  int          cap_pos = 99;
  logic [31:0] cap_bits = '0;
  logic [31:0] cap_lr = '0;
  logic        prev_bclk = 1'b0;
  logic [31:0] frames_q[$];
  logic [31:0] lr_q[$];
  int          tick_n_q[$];
  logic        ur_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (n=%0d)", name, act, exp, n);
    end
  endtask

  function automatic logic [31:0] qf(input int i);
    return (i < frames_q.size()) ? frames_q[i] : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] ql(input int i);
    return (i < lr_q.size()) ? lr_q[i] : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] qt(input int i);
    return (i < tick_n_q.size()) ? 32'(tick_n_q[i]) : 32'hxxxxxxxx;
  endfunction
  function automatic logic qu(input int i);
    return (i < ur_q.size()) ? ur_q[i] : 1'bx;
  endfunction

  task automatic tick();
    bit          is_load, ft, ready_before;
    int          f, bitc;
    logic [SW-1:0] slot;
    logic        exp_sd;
    @(posedge clk);
    ready_before = !held;
    last_acc = !arst && tx_if.sample_valid && ready_before;
    if (arst) begin
      n = 0; held = 0; hold_v = '0; last_v = '0; cur_v = '0; ur_m = 0;
    end else begin
      n++;
      is_load = (n >= P) && ((n - P) % FR == 0);
      ur_m = 0;
      if (is_load) begin
        if (held) begin
          cur_v = hold_v; held = 0;
        end else if (tx_if.sample_valid) begin
          cur_v = tx_if.sample_in;
        end else begin
          cur_v = last_v; ur_m = 1;
        end
        last_v = cur_v;
      end else if (tx_if.sample_valid && !held) begin
        hold_v = tx_if.sample_in; held = 1;
      end
    end
    #1;
    f      = n / P;
    bitc   = (NB - 1 + f) % NB;
    ft     = (n >= P) && ((n - P) % FR == 0);
    slot   = SW'(cur_v) << (SW - DW);
    exp_sd = (f == 0) ? 1'b0 : slot[SW - 1 - (bitc % SW)];
    chk("bclk", 32'(tx_if.bclk), 32'((n / BD) % 2));
    chk("lrclk", 32'(tx_if.lrclk), 32'(bitc >= SW - 1 && bitc <= NB - 2));
    chk("sdata", 32'(tx_if.sdata), 32'(exp_sd));
    chk("frame_tick", 32'(tx_if.frame_tick), 32'(ft));
    chk("underrun", 32'(tx_if.underrun), 32'(ft && ur_m));
    chk("sample_ready", 32'(tx_if.sample_ready), 32'(!held));

    if (arst) begin
      cap_pos = 99;
    end else begin
      if (tx_if.frame_tick) begin
        cap_pos = 0;
        tick_n_q.push_back(n);
        ur_q.push_back(tx_if.underrun);
      end
      if (tx_if.bclk && !prev_bclk && cap_pos < NB) begin
        cap_bits[NB - 1 - cap_pos] = tx_if.sdata;
        cap_lr[NB - 1 - cap_pos]   = tx_if.lrclk;
        cap_pos++;
        if (cap_pos == NB) begin
          frames_q.push_back(cap_bits);
          lr_q.push_back(cap_lr);
        end
      end
    end
    prev_bclk = tx_if.bclk;
  endtask

  task automatic do_reset(input int cyc);
    arst = 1'b1;
    tx_if.sample_valid = 1'b0;
    repeat (cyc) tick();
    arst = 1'b0;
    frames_q.delete(); lr_q.delete(); tick_n_q.delete(); ur_q.delete();
  endtask

  task automatic wait_frames(input int k);
    int budget;
    budget = (k + 1) * FR + 4 * P;
    while (frames_q.size() < k && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (frames_q.size() < k) begin
      errors++;
      $display("FAIL wait_frames: got %0d frames required %0d", frames_q.size(), k);
    end
  endtask

  task automatic send_one(input logic [15:0] d);
    int budget;
    budget = 2 * FR;
    tx_if.sample_valid = 1'b1;
    tx_if.sample_in    = d;
    do begin
      tick();
      budget--;
    end while (!last_acc && budget > 0);
    tx_if.sample_valid = 1'b0;
    checks++;
    if (!last_acc) begin
      errors++;
      $display("FAIL send_one: sample %h accepted %0d required 1", d, last_acc);
    end
  endtask

  initial begin
    int idx, budget, pct;
    tx_if.sample_valid = 1'b0;
    tx_if.sample_in    = '0;

    // start-up: 3-cycle reset, first frame underruns with zeros
    do_reset(3);
    chk("rst_ready", 32'(tx_if.sample_ready), 32'd1);
    chk("rst_bclk", 32'(tx_if.bclk), 32'd0);
    tick();
    chk("post_rst_ready", 32'(tx_if.sample_ready), 32'd1);
    chk("post_rst_bclk", 32'(tx_if.bclk), 32'd0);
    wait_frames(1);
    chk("first_tick_n", qt(0), 32'd4);
    chk("first_underrun", 32'(qu(0)), 32'd1);
    chk("first_frame", qf(0), 32'h0000_0000);
    chk("first_lr", ql(0), 32'h0001_FFFE);

    // single sample before the first load
    do_reset(1);
    send_one(16'hA5C3);
    wait_frames(2);
    chk("a5c3_frame", qf(0), 32'hA5C3_A5C3);
    chk("a5c3_underrun", 32'(qu(0)), 32'd0);
    chk("a5c3_lr", ql(0), 32'h0001_FFFE);
    chk("frame_period", qt(1) - qt(0), 32'd128);
    chk("a5c3_repeat", qf(1), 32'hA5C3_A5C3);

    // back-pressure stream
    do_reset(1);
    idx = 1;
    budget = 6 * FR;
    tx_if.sample_valid = 1'b1;
    tx_if.sample_in    = 16'(idx);
    while (idx <= 3 && budget > 0) begin
      tick();
      budget--;
      if (last_acc) begin
        idx++;
        tx_if.sample_in = 16'(idx);
      end
    end
    tx_if.sample_valid = 1'b0;
    wait_frames(4);
    chk("stream_f0", qf(0), 32'h0001_0001);
    chk("stream_f1", qf(1), 32'h0002_0002);
    chk("stream_f2", qf(2), 32'h0003_0003);
    chk("stream_ur", {29'd0, qu(0), qu(1), qu(2)}, 32'd0);
    chk("stream_tail_ur", 32'(qu(3)), 32'd1);

    // bypass on the load-event cycle
    do_reset(1);
    repeat (P - 1) tick();
    tx_if.sample_valid = 1'b1;
    tx_if.sample_in    = 16'h7FFF;
    tick();
    tx_if.sample_valid = 1'b0;
    chk("bypass_tick", 32'(tx_if.frame_tick), 32'd1);
    chk("bypass_underrun", 32'(tx_if.underrun), 32'd0);
    chk("bypass_ready", 32'(tx_if.sample_ready), 32'd1);
    wait_frames(2);
    chk("bypass_frame", qf(0), 32'h7FFF_7FFF);
    chk("bypass_next_ur", 32'(qu(1)), 32'd1);
    chk("bypass_next_frame", qf(1), 32'h7FFF_7FFF);

    // underrun repeat
    do_reset(1);
    send_one(16'h8000);
    wait_frames(3);
    chk("ur_f0", qf(0), 32'h8000_8000);
    chk("ur_f1", qf(1), 32'h8000_8000);
    chk("ur_f2", qf(2), 32'h8000_8000);
    chk("ur_flags", {29'd0, qu(0), qu(1), qu(2)}, 32'b011);

    // reset mid-frame with a sample held
    do_reset(1);
    send_one(16'h0BAD);
    send_one(16'h1234);
    budget = FR;
    while (n != 11 * P + 2 && budget > 0) begin tick(); budget--; end
    chk("mid_held", 32'(tx_if.sample_ready), 32'd0);
    do_reset(1);
    chk("mid_bclk", 32'(tx_if.bclk), 32'd0);
    chk("mid_lrclk", 32'(tx_if.lrclk), 32'd0);
    chk("mid_sdata", 32'(tx_if.sdata), 32'd0);
    chk("mid_ready", 32'(tx_if.sample_ready), 32'd1);
    wait_frames(1);
    chk("mid_restart_frame", qf(0), 32'h0000_0000);
    chk("mid_restart_ur", 32'(qu(0)), 32'd1);

    // randomized traffic with varying density and rare resets
    do_reset(2);
    for (int c = 0; c < 6000; c++) begin
      case ((c / 600) % 4)
        0: pct = 3;
        1: pct = 30;
        2: pct = 90;
        default: pct = 100;
      endcase
      tx_if.sample_valid = ($urandom_range(0, 99) < pct);
      tx_if.sample_in    = 16'($urandom);
      arst = ($urandom_range(0, 2499) == 0);
      tick();
    end
    arst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
